// File: rtl/npa_sched.sv
// ---------------------------------------------------------------------------
// npa_sched
//
// Shares the single NPU master DMA/AXI engine among NP cores 0..3.
// Selection is round-robin from a rotating pointer. The pointer may stay on
// the current owner for up to QMAX consecutive grants, which keeps burst
// locality without starving the other cores. Each job is supervised by a
// watchdog that force-releases an owner that never reports completion.
//
// Parameters
//   QMAX : maximum consecutive grants to one core while others wait (1..255)
//   TOUT : watchdog limit in busy cycles (0..65535, 0 disables the watchdog)
//
// Ports
//   m_axi_aclk   in   clock
//   m_axi_arstn  in   asynchronous active-low reset
//   npc_req[3:0] in   request level per core
//   npc_gnt[3:0] out  one-hot, one-cycle grant pulse to the winning core
//   npc_run[3:0] out  one-hot owner, held for the whole job
//   dma_stt      out  one-cycle job start pulse, coincides with npc_gnt
//   dma_sel[1:0] out  owner index, held until the next grant
//   dma_fin      in   one-cycle job completion pulse from the DMA engine
//   busy         out  a job is owned
//   tout         out  one-cycle watchdog expiry pulse
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module npa_sched #(
    parameter int unsigned QMAX = 4,
    parameter int unsigned TOUT = 65535
) (
    input  logic       m_axi_aclk,
    input  logic       m_axi_arstn,
    input  logic [3:0] npc_req,
    output logic [3:0] npc_gnt,
    output logic [3:0] npc_run,
    output logic       dma_stt,
    output logic [1:0] dma_sel,
    input  logic       dma_fin,
    output logic       busy,
    output logic       tout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0]  QMAX_W  = 8'(QMAX);
    localparam logic [15:0] TOUT_W  = 16'(TOUT);
    localparam logic        TOUT_EN = (TOUT != 0);

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [7:0]  streak_q, streak_d;
    logic [15:0] wdog_q, wdog_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [3:0]  run_q, run_d;
    logic        stt_q, stt_d;
    logic [1:0]  sel_q, sel_d;
    logic        busy_q, busy_d;
    logic        tout_q, tout_d;

    logic [1:0]  win_idx;
    logic        win_found;
    logic [1:0]  scan_idx;

    // Winner search: first requesting core at ptr, ptr+1, ... modulo 4.
    always_comb begin
        win_idx   = ptr_q;
        win_found = 1'b0;
        scan_idx  = '0;
        for (int i = 0; i < 4; i++) begin
            scan_idx = ptr_q + 2'(i);
            if (!win_found && npc_req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Next-state and output logic. dma_sel doubles as the last-owner record,
    // since it always holds the index of the most recent grant.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        streak_d = streak_q;
        wdog_d   = wdog_q;
        gnt_d    = 4'b0000;
        run_d    = run_q;
        stt_d    = 1'b0;
        sel_d    = sel_q;
        busy_d   = busy_q;
        tout_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = BUSY;
                    gnt_d   = 4'b0001 << win_idx;
                    run_d   = 4'b0001 << win_idx;
                    stt_d   = 1'b1;
                    sel_d   = win_idx;
                    busy_d  = 1'b1;
                    wdog_d  = '0;
                    if ((win_idx == sel_q) && (streak_q < QMAX_W)) begin
                        streak_d = streak_q + 8'd1;
                    end else begin
                        streak_d = 8'd1;
                    end
                end
            end

            BUSY: begin
                if (wdog_q != 16'hFFFF) begin
                    wdog_d = wdog_q + 16'd1;
                end
                // A finish in the start cycle is ignored. A finish that lands
                // on the expiry cycle wins over the watchdog.
                if (dma_fin && !stt_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    run_d   = 4'b0000;
                    if (streak_q < QMAX_W) begin
                        ptr_d = sel_q;
                    end else begin
                        ptr_d = sel_q + 2'd1;
                    end
                end else if (TOUT_EN && (wdog_q == TOUT_W)) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    run_d    = 4'b0000;
                    ptr_d    = sel_q + 2'd1;
                    streak_d = 8'd0;
                    tout_d   = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge m_axi_aclk or negedge m_axi_arstn) begin
        if (!m_axi_arstn) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            streak_q <= '0;
            wdog_q   <= '0;
            gnt_q    <= '0;
            run_q    <= '0;
            stt_q    <= 1'b0;
            sel_q    <= '0;
            busy_q   <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            streak_q <= streak_d;
            wdog_q   <= wdog_d;
            gnt_q    <= gnt_d;
            run_q    <= run_d;
            stt_q    <= stt_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            tout_q   <= tout_d;
        end
    end

    assign npc_gnt = gnt_q;
    assign npc_run = run_q;
    assign dma_stt = stt_q;
    assign dma_sel = sel_q;
    assign busy    = busy_q;
    assign tout    = tout_q;

endmodule

// File: tb/tb_npa_sched.sv
// ---------------------------------------------------------------------------
// tb_npa_sched
//
// Directed bench for npa_sched. Two instances share clock and reset:
//   dut 0 : QMAX=1, TOUT=65535  (single requester, reset, idle, rotation)
//   dut 1 : QMAX=2, TOUT=8      (streak, watchdog, watchdog race)
// Inputs change and outputs are sampled 1 time unit after each rising edge,
// so each sample shows the registered values of the cycle just entered.
// ---------------------------------------------------------------------------
module tb_npa_sched;

    logic       clk;
    logic       rst_n;
    logic [3:0] req  [2];
    logic       fin  [2];
    logic [3:0] gnt  [2];
    logic [3:0] run  [2];
    logic       stt  [2];
    logic [1:0] sel  [2];
    logic       busy [2];
    logic       tout [2];

    int total;
    int bad;

    npa_sched #(.QMAX(1), .TOUT(65535)) dut0 (
        .m_axi_aclk  (clk),
        .m_axi_arstn (rst_n),
        .npc_req     (req[0]),
        .npc_gnt     (gnt[0]),
        .npc_run     (run[0]),
        .dma_stt     (stt[0]),
        .dma_sel     (sel[0]),
        .dma_fin     (fin[0]),
        .busy        (busy[0]),
        .tout        (tout[0])
    );

    npa_sched #(.QMAX(2), .TOUT(8)) dut1 (
        .m_axi_aclk  (clk),
        .m_axi_arstn (rst_n),
        .npc_req     (req[1]),
        .npc_gnt     (gnt[1]),
        .npc_run     (run[1]),
        .dma_stt     (stt[1]),
        .dma_sel     (sel[1]),
        .dma_fin     (fin[1]),
        .busy        (busy[1]),
        .tout        (tout[1])
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running required=finished");
        $fatal(1, "[TB] global timeout");
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the request vector and finish pulse of one instance.
    task automatic applyStimulus(input int which, input logic [3:0] r, input logic f);
        req[which] = r;
        fin[which] = f;
    endtask

    // One counted comparison.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h required=%0h", tag, observed, expected);
        end
    endtask

    // Packed view of every output of one instance, used for all-zero checks.
    function automatic logic [31:0] allOutputs(input int which);
        return {19'd0, gnt[which], run[which], stt[which], sel[which],
                busy[which], tout[which]};
    endfunction

    // Wait (bounded) for a start pulse; reports cycles waited.
    task automatic waitGrant(input int which, output int waited);
        waited = 0;
        while (stt[which] !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        checkOutput("grant_seen", {31'd0, stt[which]}, 32'd1);
    endtask

    // Full job: expect owner, let it run len cycles past stt, pulse fin,
    // then check the release cycle.
    task automatic runJob(input int which, input int owner, input int len,
                          output int waited);
        waitGrant(which, waited);
        checkOutput("job_sel", {30'd0, sel[which]}, owner);
        checkOutput("job_gnt", {28'd0, gnt[which]}, 32'd1 << owner);
        checkOutput("job_run", {28'd0, run[which]}, 32'd1 << owner);
        repeat (len) tick();
        applyStimulus(which, req[which], 1'b1);
        tick();
        applyStimulus(which, req[which], 1'b0);
        checkOutput("job_release_busy", {31'd0, busy[which]}, 32'd0);
        checkOutput("job_release_tout", {31'd0, tout[which]}, 32'd0);
    endtask

    // Directed sequence.
    initial begin
        int waited;
        int seen;
        int rot_order[6]    = '{0, 1, 2, 3, 0, 1};
        int streak_order[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        applyStimulus(0, 4'b0000, 1'b0);
        applyStimulus(1, 4'b0000, 1'b0);

        // Reset state of both instances.
        repeat (3) tick();
        checkOutput("reset_dut0", allOutputs(0), 32'd0);
        checkOutput("reset_dut1", allOutputs(1), 32'd0);

        // Single requester: this cycle is cycle 0, fin at cycle 10.
        rst_n = 1'b1;
        applyStimulus(0, 4'b0100, 1'b0);
        tick();
        checkOutput("single_gnt", {28'd0, gnt[0]}, 32'b0100);
        checkOutput("single_stt", {31'd0, stt[0]}, 32'd1);
        checkOutput("single_sel", {30'd0, sel[0]}, 32'd2);
        checkOutput("single_run", {28'd0, run[0]}, 32'b0100);
        checkOutput("single_busy1", {31'd0, busy[0]}, 32'd1);
        tick();
        checkOutput("single_stt_drop", {31'd0, stt[0]}, 32'd0);
        checkOutput("single_gnt_drop", {28'd0, gnt[0]}, 32'd0);
        for (int c = 3; c <= 10; c++) begin
            tick();
            checkOutput("single_busy_hold", {31'd0, busy[0]}, 32'd1);
        end
        applyStimulus(0, 4'b0100, 1'b1);
        tick();
        applyStimulus(0, 4'b0000, 1'b0);
        checkOutput("single_busy11", {31'd0, busy[0]}, 32'd0);
        checkOutput("single_run11", {28'd0, run[0]}, 32'd0);
        checkOutput("single_sel_hold", {30'd0, sel[0]}, 32'd2);

        // No requests for 100 cycles: no grant, no busy.
        seen = 0;
        repeat (100) begin
            tick();
            if (gnt[0] !== 4'b0000 || busy[0] !== 1'b0) seen++;
        end
        checkOutput("idle_no_grant", seen, 32'd0);

        // Reset in the middle of a job clears every output at once.
        applyStimulus(0, 4'b0010, 1'b0);
        tick();
        checkOutput("midjob_busy", {31'd0, busy[0]}, 32'd1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midjob_reset_async", allOutputs(0), 32'd0);
        tick();
        checkOutput("midjob_reset_held", allOutputs(0), 32'd0);

        // Pure rotation from a fresh pointer (QMAX=1).
        rst_n = 1'b1;
        applyStimulus(0, 4'b1111, 1'b0);
        for (int j = 0; j < 6; j++) begin
            runJob(0, rot_order[j], 3, waited);
        end
        applyStimulus(0, 4'b0000, 1'b0);

        // Streak of two per core (QMAX=2), all cores requesting.
        applyStimulus(1, 4'b1111, 1'b0);
        for (int j = 0; j < 9; j++) begin
            runJob(1, streak_order[j], 3, waited);
        end

        // Lone requester keeps winning with only the 1-cycle gap.
        applyStimulus(1, 4'b0010, 1'b0);
        for (int j = 0; j < 4; j++) begin
            runJob(1, 1, 3, waited);
            checkOutput("lone_gap", waited, 32'd1);
        end

        // Watchdog: pointer sits at 2 now; no fin, expiry at s+9.
        applyStimulus(1, 4'b1111, 1'b0);
        waitGrant(1, waited);
        checkOutput("wd_owner", {30'd0, sel[1]}, 32'd2);
        repeat (8) tick();
        checkOutput("wd_busy_s8", {31'd0, busy[1]}, 32'd1);
        checkOutput("wd_tout_s8", {31'd0, tout[1]}, 32'd0);
        tick();
        checkOutput("wd_tout_s9", {31'd0, tout[1]}, 32'd1);
        checkOutput("wd_busy_s9", {31'd0, busy[1]}, 32'd0);
        checkOutput("wd_run_s9", {28'd0, run[1]}, 32'd0);
        tick();
        checkOutput("wd_tout_pulse", {31'd0, tout[1]}, 32'd0);

        // Next grant goes to owner+1; finish lands on the expiry cycle,
        // so it is a normal finish and the streak rule keeps core 3.
        runJob(1, 3, 8, waited);
        runJob(1, 3, 3, waited);
        runJob(1, 0, 3, waited);
        applyStimulus(1, 4'b0000, 1'b0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/npa_sched.md
# npa_sched

Round-robin scheduler that shares the single NPU master DMA/AXI engine among NP cores 0..3. It replaces fixed-priority selection with fair rotation plus a bounded same-owner streak, which keeps burst locality. It issues a one-cycle grant to the winning core and a start pulse with an owner select to the DMA engine. It also supervises each job with a watchdog that force-releases a hung owner.

## Interface
- QMAX, 4: maximum consecutive grants to one core while others wait. Range 1..255; 1 gives pure round-robin.
- TOUT, 65535: watchdog limit in busy cycles. Range 0..65535; 0 disables the watchdog.
- m_axi_aclk  in  1  clock.
- m_axi_arstn  in  1  reset, asynchronous, active-low.
- npc_req  in  4  request level from cores 0..3 (bit k = core k).
- npc_gnt  out  4  one-hot, one-cycle grant pulse to the winning core.
- npc_run  out  4  one-hot owner, held for the whole job.
- dma_stt  out  1  one-cycle job start pulse to the DMA engine; coincides with npc_gnt.
- dma_sel  out  2  owner index, held from dma_stt until the next grant.
- dma_fin  in  1  one-cycle job completion pulse from the DMA engine.
- busy  out  1  a job is owned.
- tout  out  1  one-cycle watchdog expiry pulse.

## Operation
- Reset value of every output is 0. Internal state also resets: ptr=0, streak=0, wdog=0, last owner=0, state=IDLE.
- The state machine has two states, IDLE and BUSY.
- IDLE:
  - npc_req is sampled every cycle.
  - If any bit is set, the winner k is the first set bit searching ptr, ptr+1, ... modulo 4.
  - On the next edge the block enters BUSY.
  - In that first BUSY cycle: npc_gnt[k]=1, dma_stt=1, dma_sel=k, npc_run[k]=1, busy=1.
- Streak update on each grant:
  - streak = streak+1 if k equals the last owner and streak < QMAX.
  - Otherwise streak = 1.
  - wdog is cleared.
- BUSY:
  - wdog increments each cycle, saturating at 16 bits.
  - Changes on npc_req are ignored, including owner deassertion.
  - dma_fin is ignored in the dma_stt cycle and in IDLE.
- Release occurs on the first of two events:
  - dma_fin=1 in a non-stt BUSY cycle.
  - Watchdog expiry: TOUT≠0 and no dma_fin in the TOUT cycles after dma_stt.
- On release:
  - Next state is IDLE; busy and npc_run clear.
  - dma_sel holds its value.
- Pointer update on release:
  - Normal finish: ptr = owner if streak < QMAX, otherwise ptr = owner+1 mod 4.
  - Watchdog: ptr = owner+1 mod 4, streak = 0, tout pulses.
- dma_fin in the cycle that would expire the watchdog counts as a normal finish; tout stays 0.
- The owner leads the search only if it is still requesting. Otherwise the search proceeds to the next index naturally.
- Reset mid-job: all state clears immediately. No fin or tout is generated, and the DMA engine is reset by the same signal.

## Timing
- req high at edge t, with IDLE at t: npc_gnt, dma_stt, npc_run and busy are all 1 in cycle t+1.
- Let s be the dma_stt cycle.
- dma_fin at cycle c > s: busy=0 at c+1. The earliest next grant is at c+2, so the minimum job-to-job gap is 1 idle cycle.
- Watchdog: with no dma_fin in cycles s+1..s+TOUT, tout=1 and busy=0 in cycle s+TOUT+1. This is the same cycle that busy would drop for a dma_fin at s+TOUT.
- All outputs are registered. No combinational path exists from npc_req or dma_fin to any output.
- Throughput is one job per (job length + 2) cycles.

## Test plan
- Reset and idle:
  - Assert arstn low mid-job → every output is 0 while reset is low.
  - With npc_req=0 after release → no grant for 100 cycles.
- Single requester:
  - npc_req=4'b0100 from cycle 0, dma_fin at cycle 10.
  - Expect npc_gnt=4'b0100, dma_stt=1 and dma_sel=2 at cycle 1.
  - Expect busy in cycles 1..10 and busy=0 at cycle 11.
- Pure rotation:
  - QMAX=1, npc_req=4'b1111 held, dma_fin 3 cycles after each dma_stt.
  - Expect grant order 0,1,2,3,0,1.
- Streak:
  - QMAX=2, npc_req=4'b1111 held → grant order 0,0,1,1,2,2,3,3,0.
  - QMAX=2, only npc_req[1] held → grants 1,1,1,1 with no idle beyond the 1-cycle gap.
- Watchdog:
  - TOUT=8, grant at cycle 1, no dma_fin → tout=1 and busy=0 at cycle 10.
  - Next grant goes to owner+1 when all cores are requesting.
- Watchdog race:
  - TOUT=8, dma_fin at cycle 9 (stt at 1) → busy=0 at cycle 10 with tout=0.
  - The ptr update follows the streak rule.
